regs_sb: RTL and testbench



---
 rtl/regs_sb.sv | 116 +++++++++++
 tb/tb_regs_sb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regs_sb.sv
// regs_sb: parametrised register file with two combinational read ports,
// one synchronous write port and a per-register busy scoreboard.
// Register 0 is hardwired to zero. Out-of-range addresses read as zero/ready.
module regs_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int BYPASS     = 0
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic [ADDR_WIDTH-1:0] i_reg0,
  input  logic [ADDR_WIDTH-1:0] i_reg1,
  output logic [DATA_WIDTH-1:0] o_data0,
  output logic [DATA_WIDTH-1:0] o_data1,
  output logic                  o_rdy0,
  output logic                  o_rdy1,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_reg2,
  input  logic [DATA_WIDTH-1:0] i_data2,
  input  logic                  i_mark,
  input  logic [ADDR_WIDTH-1:0] i_regm,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH:0]   o_busy_cnt
);

  localparam int CW = ADDR_WIDTH + 1;

  // Only registers 1..NUM_REGS-1 have storage; register 0 is implied zero.
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]   busy;
  logic [CW-1:0]         busy_cnt;

  logic we_ok;
  logic mark_ok;
  logic mark_new;
  logic write_clr;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  assign we_ok   = i_we && in_range(i_reg2);
  assign mark_ok = i_mark && in_range(i_regm);

  // Decide whether this edge adds or removes a busy register for the counter.
  always_comb begin
    mark_new  = 1'b0;
    write_clr = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (mark_ok && (int'(i_regm) == i) && !busy[i]) mark_new = 1'b1;
      if (we_ok && (int'(i_reg2) == i) && busy[i]) write_clr = 1'b1;
    end
    // A re-mark of the register being written keeps it busy.
    if (mark_ok && (i_regm == i_reg2)) write_clr = 1'b0;
  end

  // Read port 0: register lookup with optional same-cycle forwarding.
  always_comb begin
    o_data0 = '0;
    o_rdy0  = 1'b1;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (int'(i_reg0) == i) begin
        o_data0 = regs[i];
        o_rdy0  = !busy[i];
      end
    end
    if ((BYPASS != 0) && we_ok && (i_reg0 == i_reg2)) begin
      o_data0 = i_data2;
      o_rdy0  = 1'b1;
    end
  end

  // Read port 1: identical to port 0.
  always_comb begin
    o_data1 = '0;
    o_rdy1  = 1'b1;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (int'(i_reg1) == i) begin
        o_data1 = regs[i];
        o_rdy1  = !busy[i];
      end
    end
    if ((BYPASS != 0) && we_ok && (i_reg1 == i_reg2)) begin
      o_data1 = i_data2;
      o_rdy1  = 1'b1;
    end
  end

  // Register writes, busy set/clear and the running busy count.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (we_ok && (int'(i_reg2) == i)) begin
          regs[i] <= i_data2;
          busy[i] <= 1'b0;
        end
        // Mark is applied after the write clear so a new producer wins.
        if (!i_flush && mark_ok && (int'(i_regm) == i)) busy[i] <= 1'b1;
      end
      if (i_flush) begin
        busy     <= '0;
        busy_cnt <= '0;
      end else begin
        busy_cnt <= busy_cnt + CW'(mark_new) - CW'(write_clr);
      end
    end
  end

  assign o_busy_cnt = busy_cnt;

endmodule

// File: tb/tb_regs_sb.sv
// tb_regs_sb: directed and randomized checks of regs_sb, with one instance
// per forwarding mode sharing the same stimulus.
module tb_regs_sb;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NR = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] reg0, reg1, reg2, regm;
  logic [DW-1:0] data2;
  logic          we, mark, flush;

  logic [DW-1:0] d0_a, d1_a, d0_b, d1_b;
  logic          r0_a, r1_a, r0_b, r1_b;
  logic [AW:0]   cnt_a, cnt_b;

  regs_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .BYPASS(0)) u_nb (
    .i_CLK(clk), .i_RSTn(rst_n), .i_reg0(reg0), .i_reg1(reg1),
    .o_data0(d0_a), .o_data1(d1_a), .o_rdy0(r0_a), .o_rdy1(r1_a),
    .i_we(we), .i_reg2(reg2), .i_data2(data2), .i_mark(mark), .i_regm(regm),
    .i_flush(flush), .o_busy_cnt(cnt_a));

  regs_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .BYPASS(1)) u_by (
    .i_CLK(clk), .i_RSTn(rst_n), .i_reg0(reg0), .i_reg1(reg1),
    .o_data0(d0_b), .o_data1(d1_b), .o_rdy0(r0_b), .o_rdy1(r1_b),
    .i_we(we), .i_reg2(reg2), .i_data2(data2), .i_mark(mark), .i_regm(regm),
    .i_flush(flush), .o_busy_cnt(cnt_b));

  // Reference state: contents and busy flags of every architectural register.
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  int n_cmp;
  int n_fail;

  function automatic bit in_rng(input logic [AW-1:0] a);
    return (a != 0) && (int'(a) < NR);
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (!in_rng(a)) return '0;
    if (byp && we && in_rng(reg2) && reg2 == a) return data2;
    return m_regs[int'(a)];
  endfunction

  function automatic logic exp_rdy(input logic [AW-1:0] a, input bit byp);
    if (!in_rng(a)) return 1'b1;
    if (byp && we && in_rng(reg2) && reg2 == a) return 1'b1;
    return !m_busy[int'(a)];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < NR; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Clock-edge behaviour: write (clearing busy), then flush or mark.
  task automatic model_apply();
    if (we && in_rng(reg2)) begin
      m_regs[int'(reg2)] = data2;
      m_busy[int'(reg2)] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    end else if (mark && in_rng(regm)) begin
      m_busy[int'(regm)] = 1'b1;
    end
  endtask

  task automatic idle();
    we = 1'b0; mark = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_apply();
    #1;
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); reg0 = 5'd3; reg1 = 5'd0; reg2 = '0; regm = '0; data2 = '0;
    model_reset();
    #7;
    n_cmp++; if (d0_a !== 8'h00) begin n_fail++; $display("FAIL reset_data0 got %h exp 00", d0_a); end
    n_cmp++; if (r0_a !== 1'b1 || r1_a !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b%b exp 11", r0_a, r1_a); end
    n_cmp++; if (cnt_a !== 6'd0 || cnt_b !== 6'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0", cnt_a, cnt_b); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    we = 1'b1; reg2 = 5'd1; data2 = 8'h55;
    tick();
    reg0 = 5'd1; reg1 = 5'd2; #1;
    n_cmp++; if (d0_a !== 8'h55) begin n_fail++; $display("FAIL wr_rd_data0 got %h exp 55", d0_a); end
    n_cmp++; if (r0_a !== 1'b1) begin n_fail++; $display("FAIL wr_rd_rdy0 got %b exp 1", r0_a); end
    n_cmp++; if (d1_a !== 8'h00) begin n_fail++; $display("FAIL wr_rd_data1 got %h exp 00", d1_a); end
  endtask

  task automatic test_r0_oor();
    we = 1'b1; reg2 = 5'd0; data2 = 8'hFF;
    tick();
    reg0 = 5'd0; reg1 = 5'd25; #1;
    n_cmp++; if (d0_a !== 8'h00 || r0_a !== 1'b1) begin n_fail++; $display("FAIL r0_read got %h/%b exp 00/1", d0_a, r0_a); end
    n_cmp++; if (d1_a !== 8'h00 || r1_a !== 1'b1) begin n_fail++; $display("FAIL oor_read got %h/%b exp 00/1", d1_a, r1_a); end
    mark = 1'b1; regm = 5'd25;
    tick();
    n_cmp++; if (cnt_a !== 6'd0) begin n_fail++; $display("FAIL oor_mark_cnt got %0d exp 0", cnt_a); end
    we = 1'b1; reg2 = 5'd22; data2 = 8'h9C;
    tick();
    reg0 = 5'd22; #1;
    n_cmp++; if (d0_a !== 8'h00) begin n_fail++; $display("FAIL oor_write got %h exp 00", d0_a); end
  endtask

  task automatic test_scoreboard();
    mark = 1'b1; regm = 5'd3;
    tick();
    reg0 = 5'd3; #1;
    n_cmp++; if (r0_a !== 1'b0) begin n_fail++; $display("FAIL sb_mark_rdy got %b exp 0", r0_a); end
    n_cmp++; if (cnt_a !== 6'd1) begin n_fail++; $display("FAIL sb_mark_cnt got %0d exp 1", cnt_a); end
    mark = 1'b1; regm = 5'd3;
    tick();
    n_cmp++; if (cnt_a !== 6'd1) begin n_fail++; $display("FAIL sb_remark_cnt got %0d exp 1", cnt_a); end
    we = 1'b1; reg2 = 5'd3; data2 = 8'h12;
    tick();
    n_cmp++; if (r0_a !== 1'b1 || d0_a !== 8'h12) begin n_fail++; $display("FAIL sb_write got %h/%b exp 12/1", d0_a, r0_a); end
    n_cmp++; if (cnt_a !== 6'd0) begin n_fail++; $display("FAIL sb_write_cnt got %0d exp 0", cnt_a); end
  endtask

  task automatic test_simultaneous();
    mark = 1'b1; regm = 5'd4; we = 1'b1; reg2 = 5'd4; data2 = 8'h34;
    tick();
    reg0 = 5'd4; #1;
    n_cmp++; if (d0_a !== 8'h34 || r0_a !== 1'b0) begin n_fail++; $display("FAIL sim_wm got %h/%b exp 34/0", d0_a, r0_a); end
    n_cmp++; if (cnt_a !== 6'd1) begin n_fail++; $display("FAIL sim_wm_cnt got %0d exp 1", cnt_a); end
    mark = 1'b1; regm = 5'd5; flush = 1'b1;
    tick();
    reg0 = 5'd4; reg1 = 5'd5; #1;
    n_cmp++; if (cnt_a !== 6'd0 || cnt_b !== 6'd0) begin n_fail++; $display("FAIL sim_flush_cnt got %0d/%0d exp 0", cnt_a, cnt_b); end
    n_cmp++; if (r0_a !== 1'b1 || r1_a !== 1'b1) begin n_fail++; $display("FAIL sim_flush_rdy got %b%b exp 11", r0_a, r1_a); end
  endtask

  task automatic test_bypass();
    mark = 1'b1; regm = 5'd5;
    tick();
    reg0 = 5'd5; reg1 = 5'd5; we = 1'b1; reg2 = 5'd5; data2 = 8'h77; #1;
    n_cmp++; if (d0_b !== 8'h77 || d1_b !== 8'h77) begin n_fail++; $display("FAIL byp_data got %h/%h exp 77", d0_b, d1_b); end
    n_cmp++; if (r0_b !== 1'b1 || r1_b !== 1'b1) begin n_fail++; $display("FAIL byp_rdy got %b%b exp 11", r0_b, r1_b); end
    n_cmp++; if (d0_a !== 8'h00 || d1_a !== 8'h00) begin n_fail++; $display("FAIL nobyp_old got %h/%h exp 00", d0_a, d1_a); end
    n_cmp++; if (r0_a !== 1'b0) begin n_fail++; $display("FAIL nobyp_rdy got %b exp 0", r0_a); end
    tick();
    n_cmp++; if (d0_a !== 8'h77 || r0_a !== 1'b1) begin n_fail++; $display("FAIL nobyp_next got %h/%b exp 77/1", d0_a, r0_a); end
    n_cmp++; if (cnt_a !== 6'd0) begin n_fail++; $display("FAIL byp_cnt got %0d exp 0", cnt_a); end
  endtask

  task automatic test_async_reset();
    we = 1'b1; reg2 = 5'd6; data2 = 8'hA5;
    tick();
    mark = 1'b1; regm = 5'd7;
    tick();
    reg0 = 5'd6; reg1 = 5'd7; #1;
    n_cmp++; if (d0_a !== 8'hA5 || r1_a !== 1'b0 || cnt_a !== 6'd1) begin n_fail++; $display("FAIL ar_pre got %h/%b/%0d exp a5/0/1", d0_a, r1_a, cnt_a); end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (d0_a !== 8'h00 || d0_b !== 8'h00) begin n_fail++; $display("FAIL ar_data got %h/%h exp 00", d0_a, d0_b); end
    n_cmp++; if (r0_a !== 1'b1 || r1_a !== 1'b1 || r1_b !== 1'b1) begin n_fail++; $display("FAIL ar_rdy got %b%b%b exp 111", r0_a, r1_a, r1_b); end
    n_cmp++; if (cnt_a !== 6'd0 || cnt_b !== 6'd0) begin n_fail++; $display("FAIL ar_cnt got %0d/%0d exp 0", cnt_a, cnt_b); end
    rst_n = 1'b1;
    we = 1'b1; reg2 = 5'd6; data2 = 8'h3C;
    tick();
    #1;
    n_cmp++; if (d0_a !== 8'h3C) begin n_fail++; $display("FAIL ar_first_edge got %h exp 3c", d0_a); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reg0  = AW'($urandom_range(0, 31));
      reg1  = ($urandom_range(0, 3) == 0) ? reg0 : AW'($urandom_range(0, 31));
      reg2  = ($urandom_range(0, 2) == 0) ? reg0 : AW'($urandom_range(0, 23));
      regm  = ($urandom_range(0, 3) == 0) ? reg2 : AW'($urandom_range(0, 23));
      data2 = DW'($urandom);
      we    = ($urandom_range(0, 1) == 1);
      mark  = ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 19) == 0);
      #2;
      n_cmp++;
      if (d0_a !== exp_data(reg0, 0) || d1_a !== exp_data(reg1, 0) ||
          r0_a !== exp_rdy(reg0, 0) || r1_a !== exp_rdy(reg1, 0)) begin
        n_fail++;
        $display("FAIL rnd_nb[%0d] got %h/%h/%b%b exp %h/%h/%b%b", n, d0_a, d1_a, r0_a, r1_a,
                 exp_data(reg0, 0), exp_data(reg1, 0), exp_rdy(reg0, 0), exp_rdy(reg1, 0));
      end
      n_cmp++;
      if (d0_b !== exp_data(reg0, 1) || d1_b !== exp_data(reg1, 1) ||
          r0_b !== exp_rdy(reg0, 1) || r1_b !== exp_rdy(reg1, 1)) begin
        n_fail++;
        $display("FAIL rnd_byp[%0d] got %h/%h/%b%b exp %h/%h/%b%b", n, d0_b, d1_b, r0_b, r1_b,
                 exp_data(reg0, 1), exp_data(reg1, 1), exp_rdy(reg0, 1), exp_rdy(reg1, 1));
      end
      n_cmp++;
      if (int'(cnt_a) != exp_cnt() || int'(cnt_b) != exp_cnt()) begin
        n_fail++;
        $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d", n, cnt_a, cnt_b, exp_cnt());
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_r0_oor();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
